// File: rtl/mdu_sequencer.sv
// HI/LO multiply/divide sequencer for the E stage: latches results on issue and commits them after a busy countdown.
// Optional MDU_DIV0_SKIP_EN: a divide by zero finishes after one busy cycle instead of DIV_CYCLES.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  start,
  input  logic [1:0]  MD,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        req,
  input  logic        MDuse,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        start_v, is_div, div0;
  logic [3:0]  load_cnt;
  logic [63:0] res;

  // Results are packed as {remainder/high, quotient/low}.
  function automatic logic [63:0] smul(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return p;
  endfunction

  function automatic logic [63:0] umul(input logic [31:0] a, input logic [31:0] b);
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [63:0] udiv(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = (b == 32'd0) ? 32'd1 : b;
    return {a % d, a / d};
  endfunction

  // Magnitude divide then fix signs: quotient truncates toward zero,
  // remainder follows the dividend; 0x80000000 / -1 falls out as 0x80000000 r 0.
  function automatic logic [63:0] sdiv(input logic signed [31:0] a, input logic signed [31:0] b);
    logic [31:0] ua, ub, ma, mb, uq, ur, q, r;
    ua = a;
    ub = b;
    ma = a[31] ? (~ua + 32'd1) : ua;
    mb = b[31] ? (~ub + 32'd1) : ub;
    if (mb == 32'd0) mb = 32'd1;
    uq = ma / mb;
    ur = ma % mb;
    q  = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
    r  = a[31] ? (~ur + 32'd1) : ur;
    return {r, q};
  endfunction

  assign start_v = (start != 3'd0) && (start <= 3'd4);
  assign is_div  = (start == 3'd3) || (start == 3'd4);
  assign div0    = is_div && (rt_data == 32'd0);

`ifdef MDU_DIV0_SKIP_EN
  assign load_cnt = is_div ? (div0 ? 4'd1 : 4'(DIV_CYCLES)) : 4'(MULT_CYCLES);
`else
  assign load_cnt = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
`endif

  always_comb begin
    res = 64'd0;
    case (start)
      3'd1:    res = smul(rs_data, rt_data);
      3'd2:    res = umul(rs_data, rt_data);
      3'd3:    res = sdiv(rs_data, rt_data);
      3'd4:    res = udiv(rs_data, rt_data);
      default: res = 64'd0;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (!req) begin
      if (start_v) begin
        cnt_d = load_cnt;
        // A zero divisor commits the current HI/LO, i.e. leaves them unchanged.
        if (div0) begin
          pend_hi_d = hi_q;
          pend_lo_d = lo_q;
        end else begin
          pend_hi_d = res[63:32];
          pend_lo_d = res[31:0];
        end
      end else if (MD == 2'd1) begin
        hi_d = rs_data;
      end else if (MD == 2'd3) begin
        lo_d = rs_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy  = (cnt_q != 4'd0) | (start_v & ~req);
  assign stall = MDuse & busy;
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: cycle-time reference model checked every cycle, plus directed literal checks.
module tb_mdu_sequencer;
  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_DIV0_SKIP_EN
  localparam int DIV0_BUSY = 2;
`else
  localparam int DIV0_BUSY = DC + 1;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  start = 3'd0;
  logic [1:0]  MD = 2'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        req = 1'b0;
  logic        MDuse = 1'b0;
  logic        busy, stall;
  logic [31:0] HI, LO;

  int tests = 0;
  int fails = 0;

  mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rstn(rstn), .start(start), .MD(MD), .rs_data(rs_data),
    .rt_data(rt_data), .req(req), .MDuse(MDuse), .busy(busy), .stall(stall),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a start accepted in cycle c makes the unit busy through
  // cycle c+N and commits its result on the edge ending cycle c+N.
  function automatic int op_cycles(input logic [2:0] op, input logic [31:0] b);
    if (op <= 3'd2) return MC;
`ifdef MDU_DIV0_SKIP_EN
    if (b == 32'd0) return 1;
`endif
    return DC;
  endfunction

  function automatic logic [63:0] op_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint p;
    sa = a;
    sb = b;
    case (op)
      3'd1: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      3'd2: return {32'b0, a} * {32'b0, b};
      3'd3: begin
        if (b == 32'd0) return 64'd0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd4: begin
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  int          cyc;
  int          done_at;
  logic        m_wr;
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  logic        m_busy, m_stall;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc <= 0; done_at <= -1; m_wr <= 1'b0;
      m_hi <= 32'd0; m_lo <= 32'd0; r_hi <= 32'd0; r_lo <= 32'd0;
    end else begin
      cyc <= cyc + 1;
      if (cyc == done_at) begin
        if (m_wr) begin
          m_hi <= r_hi;
          m_lo <= r_lo;
        end
      end else if (cyc > done_at && !req) begin
        if (start >= 3'd1 && start <= 3'd4) begin
          done_at <= cyc + op_cycles(start, rt_data);
          {r_hi, r_lo} <= op_result(start, rs_data, rt_data);
          m_wr <= !(start >= 3'd3 && rt_data == 32'd0);
        end else if (MD == 2'd1) begin
          m_hi <= rs_data;
        end else if (MD == 2'd3) begin
          m_lo <= rs_data;
        end
      end
    end
  end

  assign m_busy  = (cyc <= done_at) || ((start >= 3'd1 && start <= 3'd4) && !req);
  assign m_stall = MDuse && m_busy;

  always @(negedge clk) begin
    chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
    chk("cyc_stall", {31'b0, stall}, {31'b0, m_stall});
    chk("cyc_HI", HI, m_hi);
    chk("cyc_LO", LO, m_lo);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic mu, input logic mmd, input logic mrq,
                        output int nb, output int ns);
    start = op; rs_data = a; rt_data = b; MDuse = mu;
    nb = 0; ns = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (stall) ns++;
      step();
      start = 3'd0; MD = 2'd0; req = 1'b0;
      if (k == 0) begin
        if (mmd) begin
          MD = 2'd1;
          rs_data = 32'h1234;
        end
        req = mrq;
      end
    end
    MDuse = 1'b0;
    step();
  endtask

  task automatic md_write(input logic [1:0] md, input logic [31:0] v);
    MD = md; rs_data = v;
    step();
    MD = 2'd0;
  endtask

  initial begin
    int nb, ns;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    step();

    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 1'b0, nb, ns);
    chk("mult_busy_cycles", 32'(nb), 32'd6);
    chk("mult_HI", HI, 32'hFFFF_FFFF);
    chk("mult_LO", LO, 32'hFFFF_FFF1);

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, nb, ns);
    chk("div_busy_cycles", 32'(nb), 32'd11);
    chk("div_LO", LO, 32'hFFFF_FFFD);
    chk("div_HI", HI, 32'hFFFF_FFFF);

    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, nb, ns);
    chk("divu_LO", LO, 32'h7FFF_FFFC);
    chk("divu_HI", HI, 32'd1);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, nb, ns);
    chk("divovf_LO", LO, 32'h8000_0000);
    chk("divovf_HI", HI, 32'd0);

    run_op(3'd1, 32'd2, 32'd3, 1'b1, 1'b1, 1'b0, nb, ns);
    chk("stall_busy_cycles", 32'(nb), 32'd6);
    chk("stall_cycles", 32'(ns), 32'd6);
    chk("mthi_run_HI", HI, 32'd0);
    chk("mult6_LO", LO, 32'd6);
    md_write(2'd1, 32'h1234);
    @(negedge clk);
    chk("mthi_idle_HI", HI, 32'h1234);
    step();

    start = 3'd1; rs_data = 32'd7; rt_data = 32'd7; req = 1'b1;
    @(negedge clk);
    chk("req_start_busy", {31'b0, busy}, 32'd0);
    step();
    start = 3'd0; req = 1'b0;
    repeat (7) step();
    @(negedge clk);
    chk("req_start_HI", HI, 32'h1234);
    chk("req_start_LO", LO, 32'd6);
    step();

    run_op(3'd2, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b1, nb, ns);
    chk("req_mid_busy_cycles", 32'(nb), 32'd6);
    chk("req_mid_HI", HI, 32'd1);
    chk("req_mid_LO", LO, 32'd0);

    md_write(2'd1, 32'hA);
    md_write(2'd3, 32'hB);
    run_op(3'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, nb, ns);
    chk("div0_busy_cycles", 32'(nb), 32'(DIV0_BUSY));
    chk("div0_HI", HI, 32'hA);
    chk("div0_LO", LO, 32'hB);

    start = 3'd3; rs_data = 32'd100; rt_data = 32'd7; MDuse = 1'b1;
    step();
    start = 3'd0;
    step(); step();
    #1 rstn = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_stall", {31'b0, stall}, 32'd0);
    chk("arst_HI", HI, 32'd0);
    chk("arst_LO", LO, 32'd0);
    MDuse = 1'b0;
    step(); step();
    #1 rstn = 1'b1;
    repeat (15) step();
    @(negedge clk);
    chk("post_rst_HI", HI, 32'd0);
    chk("post_rst_LO", LO, 32'd0);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
